// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection plus a circular
// return-address stack that pushes on calls and pops on returns.
module pc_sequencer #(
  parameter int ADDR_W = 32,
  parameter int OFFSET_W = 26,
  parameter int RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic                          iStall,
  input  logic                          iBranchCmd,
  input  logic [ADDR_W-1:0]             iBranchAddr,
  input  logic                          iJumpCmd,
  input  logic                          iCallCmd,
  input  logic [OFFSET_W-1:0]           iOffset,
  input  logic                          iRetCmd,
  input  logic [ADDR_W-1:0]             iRetAddr,
  input  logic                          iBranchMissCmd,
  input  logic [ADDR_W-1:0]             iBranchMissAddr,
  output logic [ADDR_W-1:0]             oPC,
  output logic [ADDR_W-1:0]             oPCPlus4,
  output logic [$clog2(RAS_DEPTH):0]    oRasCount,
  output logic                          oRasEmpty,
  output logic                          oRasFull,
  output logic                          oRasOverflow,
  output logic                          oRetFromRas
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pcReg;
  logic [ADDR_W-1:0] nextPc;
  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  topPtr;
  logic [PTR_W-1:0]  topIdx;
  logic [CNT_W-1:0]  rasCount;
  logic              overflowReg;
  logic              retFromRas;
  logic              doPush;
  logic              doPop;

  assign oPC          = pcReg;
  assign oPCPlus4     = pcReg + ADDR_W'(4);
  assign oRasCount    = rasCount;
  assign oRasEmpty    = (rasCount == '0);
  assign oRasFull     = (rasCount == CNT_W'(RAS_DEPTH));
  assign oRasOverflow = overflowReg;
  assign oRetFromRas  = retFromRas;

  // topPtr addresses the next free slot, so the live top sits one below it.
  assign topIdx = topPtr - PTR_W'(1);

  always_comb begin
    nextPc     = oPCPlus4;
    retFromRas = iRetCmd & ~iBranchMissCmd & ~iJumpCmd & (rasCount != '0);
    doPush     = iJumpCmd & iCallCmd & ~iBranchMissCmd & ~iStall;
    doPop      = retFromRas & ~iStall;
    if (iBranchMissCmd) begin
      nextPc = iBranchMissAddr;
    end else if (iJumpCmd) begin
      nextPc = {oPCPlus4[ADDR_W-1:OFFSET_W], iOffset};
    end else if (iRetCmd) begin
      nextPc = retFromRas ? rasMem[topIdx] : iRetAddr;
    end else if (iBranchCmd) begin
      nextPc = iBranchAddr;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pcReg       <= RESET_PC;
      topPtr      <= '0;
      rasCount    <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (iBranchMissCmd || !iStall) begin
        pcReg <= nextPc;
      end
      // A push on a full stack overwrites the oldest slot; count saturates.
      if (doPush) begin
        topPtr <= topPtr + PTR_W'(1);
        if (rasCount == CNT_W'(RAS_DEPTH)) begin
          overflowReg <= 1'b1;
        end else begin
          rasCount <= rasCount + CNT_W'(1);
        end
      end else if (doPop) begin
        topPtr   <= topIdx;
        rasCount <= rasCount - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (doPush && !iReset) begin
      rasMem[topPtr] <= oPCPlus4;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// commands compared against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        iReset, iStall, iBranchCmd, iJumpCmd, iCallCmd, iRetCmd, iBranchMissCmd;
  logic [31:0] iBranchAddr, iRetAddr, iBranchMissAddr;
  logic [25:0] iOffset;
  logic [31:0] oPC, oPCPlus4;
  logic [3:0]  oRasCount;
  logic        oRasEmpty, oRasFull, oRasOverflow, oRetFromRas;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  bit          m_ovf;

  pc_sequencer #(.ADDR_W(32), .OFFSET_W(26), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .iClk(clk), .iReset(iReset), .iStall(iStall),
    .iBranchCmd(iBranchCmd), .iBranchAddr(iBranchAddr),
    .iJumpCmd(iJumpCmd), .iCallCmd(iCallCmd), .iOffset(iOffset),
    .iRetCmd(iRetCmd), .iRetAddr(iRetAddr),
    .iBranchMissCmd(iBranchMissCmd), .iBranchMissAddr(iBranchMissAddr),
    .oPC(oPC), .oPCPlus4(oPCPlus4), .oRasCount(oRasCount),
    .oRasEmpty(oRasEmpty), .oRasFull(oRasFull),
    .oRasOverflow(oRasOverflow), .oRetFromRas(oRetFromRas)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic clear_inputs();
    iReset = 0; iStall = 0; iBranchCmd = 0; iJumpCmd = 0; iCallCmd = 0;
    iRetCmd = 0; iBranchMissCmd = 0;
    iBranchAddr = 0; iRetAddr = 0; iBranchMissAddr = 0; iOffset = 0;
  endtask

  function automatic logic [31:0] model_ret_expected();
    if (!iBranchMissCmd && !iJumpCmd && iRetCmd && m_stack.size() > 0) return 1;
    return 0;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (iReset) begin
      m_pc = 32'h0;
      m_stack.delete();
      m_ovf = 0;
    end else if (iBranchMissCmd) begin
      m_pc = iBranchMissAddr;
    end else if (!iStall) begin
      if (iJumpCmd) begin
        if (iCallCmd) begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1;
          end
          m_stack.push_back(p4);
        end
        m_pc = {p4[31:26], iOffset};
      end else if (iRetCmd) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_pc = iRetAddr;
      end else if (iBranchCmd) begin
        m_pc = iBranchAddr;
      end else begin
        m_pc = p4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    clear_inputs();
    iBranchCmd = 1; iBranchAddr = addr;
    step();
    clear_inputs();
  endtask

  task automatic call(input logic [25:0] off);
    clear_inputs();
    iJumpCmd = 1; iCallCmd = 1; iOffset = off;
    step();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    iReset = 1;
    step();
    clear_inputs();
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (oPC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", oPC, 32'h0); end
    n_tests++;
    if (oRasCount !== 4'd0 || oRasEmpty !== 1'b1 || oRasOverflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ras: count %0d empty %b ovf %b exp 0 1 0", oRasCount, oRasEmpty, oRasOverflow);
    end
  endtask

  task automatic test_idle();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (oPC !== exp_pc[i] || oRasEmpty !== 1'b1) begin
        n_fail++; $display("FAIL idle_%0d: pc %h empty %b exp %h 1", i, oPC, oRasEmpty, exp_pc[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    go_to(32'h100);
    call(26'h40);
    n_tests++;
    if (oPC !== 32'h40 || oRasCount !== 4'd1) begin
      n_fail++; $display("FAIL call: pc %h count %0d exp 00000040 1", oPC, oRasCount);
    end
    iRetCmd = 1;
    #1;
    n_tests++;
    if (oRetFromRas !== 1'b1) begin n_fail++; $display("FAIL ret_from_ras: got %b exp 1", oRetFromRas); end
    step();
    clear_inputs();
    n_tests++;
    if (oPC !== 32'h104 || oRasCount !== 4'd0) begin
      n_fail++; $display("FAIL ret: pc %h count %0d exp 00000104 0", oPC, oRasCount);
    end
  endtask

  task automatic test_priority();
    logic [3:0] cnt_before;
    for (int s = 0; s < 2; s++) begin
      go_to(32'h200);
      cnt_before = oRasCount;
      iStall = (s == 1); iBranchCmd = 1; iBranchAddr = 32'h300;
      iJumpCmd = 1; iCallCmd = 1; iOffset = 26'h80; iRetCmd = 1; iRetAddr = 32'h400;
      iBranchMissCmd = 1; iBranchMissAddr = 32'h500;
      step();
      clear_inputs();
      n_tests++;
      if (oPC !== 32'h500 || oRasCount !== cnt_before) begin
        n_fail++; $display("FAIL priority_stall%0d: pc %h count %0d exp 00000500 %0d", s, oPC, oRasCount, cnt_before);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc_hold;
    do_reset();
    call(26'h1000);
    call(26'h2000);
    pc_hold = oPC;
    iRetCmd = 1; iStall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (oPC !== pc_hold || oRasCount !== 4'd2) begin
        n_fail++; $display("FAIL stall_%0d: pc %h count %0d exp %h 2", i, oPC, oRasCount, pc_hold);
      end
    end
    iStall = 0;
    step();
    clear_inputs();
    n_tests++;
    // Second call was made from 0x1000, so it returns to 0x1004.
    if (oPC !== 32'h1004 || oRasCount !== 4'd1) begin
      n_fail++; $display("FAIL stall_release: pc %h count %0d exp 00001004 1", oPC, oRasCount);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) call(26'(32'h1000 + i * 32'h100));
    n_tests++;
    if (oRasFull !== 1'b1 || oRasOverflow !== 1'b1 || oRasCount !== 4'd8) begin
      n_fail++; $display("FAIL overflow: full %b ovf %b count %0d exp 1 1 8", oRasFull, oRasOverflow, oRasCount);
    end
    for (int i = 0; i < 9; i++) begin
      logic [31:0] exp_pc;
      // Newest return is after the call at 0x1700 (the 8th target); oldest kept is after reset-PC 0's successor chain.
      exp_pc = (i == 0) ? 32'h1704 : (i < 8) ? 32'h1000 + (7 - i) * 32'h100 + 32'h4 : 32'hDEAD0000;
      if (i == 7) exp_pc = 32'h1004;
      clear_inputs();
      iRetCmd = 1; iRetAddr = 32'hDEAD0000;
      #1;
      n_tests++;
      if (oRetFromRas !== (i < 8)) begin
        n_fail++; $display("FAIL ovf_ret_src_%0d: got %b exp %b", i, oRetFromRas, (i < 8));
      end
      step();
      n_tests++;
      if (oPC !== exp_pc || oPC !== m_pc) begin
        n_fail++; $display("FAIL ovf_ret_pc_%0d: got %h exp %h", i, oPC, exp_pc);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap_and_reset();
    go_to(32'hFFFF_FFFC);
    step();
    n_tests++;
    if (oPC !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h exp 00000000", oPC); end
    iReset = 1; iStall = 1; iBranchMissCmd = 1; iBranchMissAddr = 32'h900;
    step();
    clear_inputs();
    n_tests++;
    if (oPC !== 32'h0 || oRasOverflow !== 1'b0 || oRasCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_over_stall: pc %h ovf %b count %0d exp 0 0 0", oPC, oRasOverflow, oRasCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      iReset         = ($urandom_range(0, 99) == 0);
      iStall         = ($urandom_range(0, 7) == 0);
      iBranchMissCmd = ($urandom_range(0, 15) == 0);
      iJumpCmd       = ($urandom_range(0, 3) == 0);
      iCallCmd       = ($urandom_range(0, 1) == 0);
      iRetCmd        = ($urandom_range(0, 3) == 0);
      iBranchCmd     = ($urandom_range(0, 4) == 0);
      iOffset        = 26'($urandom);
      iBranchAddr    = $urandom;
      iRetAddr       = $urandom;
      iBranchMissAddr = $urandom;
      #1;
      n_tests++;
      if (oRetFromRas !== model_ret_expected()[0] || oPCPlus4 !== m_pc + 32'd4) begin
        n_fail++; $display("FAIL rand_comb_%0d: ret %b p4 %h exp %b %h", i, oRetFromRas, oPCPlus4, model_ret_expected()[0], m_pc + 32'd4);
      end
      step();
      n_tests++;
      if (oPC !== m_pc || oRasCount !== 4'(m_stack.size()) || oRasOverflow !== m_ovf ||
          oRasEmpty !== (m_stack.size() == 0) || oRasFull !== (m_stack.size() == DEPTH)) begin
        n_fail++; $display("FAIL rand_state_%0d: pc %h cnt %0d ovf %b exp %h %0d %b", i, oPC, oRasCount, oRasOverflow, m_pc, m_stack.size(), m_ovf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_pc = 0; m_ovf = 0;
    test_reset();
    test_idle();
    test_call_ret();
    test_priority();
    test_stall();
    test_overflow();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
